// File: rtl/conv_pool2x2.sv
// conv_pool2x2: streaming 2x2 stride-2 pooling (max or average) with optional
// ReLU, fed by a raster-order stream of signed convolution results. Only a
// half-row of partial window values is stored, never a full frame.
module conv_pool2x2 #(
    parameter int DW = 16,
    parameter int W  = 4,
    parameter int H  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_data,
    input  logic                 pool_mode,
    input  logic                 relu_en,
    output logic                 out_valid,
    output logic signed [DW-1:0] out_data,
    output logic                 frame_done
);

    // Two guard bits let a four-sample sum never overflow.
    localparam int SW = DW + 2;
    localparam int CW = $clog2(W);
    localparam int RW = $clog2(H);
    localparam int HW = (W > 2) ? $clog2(W / 2) : 1;

    typedef enum logic {
        IDLE,
        ACC
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic                  mode_q, mode_d;
    logic                  relu_q, relu_d;
    logic signed [SW-1:0]  buf_q [W/2];
    logic signed [SW-1:0]  buf_d [W/2];
    logic                  out_valid_q, out_valid_d;
    logic signed [DW-1:0]  out_data_q, out_data_d;
    logic                  frame_done_q, frame_done_d;

    logic [HW-1:0]         buf_idx;
    logic                  eff_mode;
    logic                  eff_relu;
    logic signed [SW-1:0]  x_ext;
    logic signed [SW-1:0]  entry;
    logic signed [SW-1:0]  folded;
    logic signed [SW-1:0]  avg_ext;
    logic signed [DW-1:0]  pool_res;
    logic signed [DW-1:0]  final_res;

    // The first beat of a frame uses the live mode inputs; later beats use
    // the values latched on that first beat.
    assign eff_mode = (state_q == IDLE) ? pool_mode : mode_q;
    assign eff_relu = (state_q == IDLE) ? relu_en   : relu_q;
    assign buf_idx  = HW'(col_q >> 1);
    assign x_ext    = SW'(in_data);
    assign entry    = buf_q[buf_idx];

    // Fold the incoming sample into the window's partial value and form the
    // pooled result used when this beat completes a window.
    always_comb begin
        if (eff_mode) begin
            folded = entry + x_ext;
        end else begin
            folded = (x_ext > entry) ? x_ext : entry;
        end
        avg_ext   = folded >>> 2;
        pool_res  = eff_mode ? avg_ext[DW-1:0] : folded[DW-1:0];
        final_res = (eff_relu && pool_res < 0) ? '0 : pool_res;
    end

    // Next-state, counters, partial buffer and registered output.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        mode_d       = mode_q;
        relu_d       = relu_q;
        buf_d        = buf_q;
        out_valid_d  = 1'b0;
        out_data_d   = '0;
        frame_done_d = 1'b0;

        if (in_valid) begin
            if (state_q == IDLE) begin
                mode_d  = pool_mode;
                relu_d  = relu_en;
                state_d = ACC;
            end

            if (!row_q[0] && !col_q[0]) begin
                buf_d[buf_idx] = x_ext;
            end else if (row_q[0] && col_q[0]) begin
                out_valid_d = 1'b1;
                out_data_d  = final_res;
            end else begin
                buf_d[buf_idx] = folded;
            end

            if (col_q == CW'(W - 1)) begin
                col_d = '0;
                if (row_q == RW'(H - 1)) begin
                    row_d        = '0;
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // State and datapath registers with asynchronous reset.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            mode_q       <= 1'b0;
            relu_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            frame_done_q <= 1'b0;
            // NOTE: the partial buffer is only W/2 entries, so clearing it on reset is cheap
            // and guarantees no stale partial data survives an aborted frame.
            for (int i = 0; i < W / 2; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            mode_q       <= mode_d;
            relu_q       <= relu_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            frame_done_q <= frame_done_d;
            for (int i = 0; i < W / 2; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_pool2x2.sv
// tb_conv_pool2x2: scoreboard bench for conv_pool2x2 with W=H=4, DW=16.
// Expected window results and their due cycles are queued when the
// completing beat is driven and compared when the DUT emits output.
module tb_conv_pool2x2;

    localparam int DW = 16;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int NP = W * H;

    typedef int frame_t [NP];

    typedef struct {
        int val;
        int fd;
        int due;
    } exp_t;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic                 pool_mode;
    logic                 relu_en;
    logic                 out_valid;
    logic signed [DW-1:0] out_data;
    logic                 frame_done;

    int   n_checks;
    int   n_fail;
    int   cyc;
    bit   in_reset;
    exp_t sb_q [$];
    exp_t e;

    conv_pool2x2 #(.DW(DW), .W(W), .H(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .pool_mode  (pool_mode),
        .relu_en    (relu_en),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference pooling of window (r, c) computed directly from the frame.
    function automatic int pool_ref(input frame_t p, input int r, input int c,
                                    input bit mode, input bit relu);
        int a, b, d, f, s, res;
        a = p[(2 * r) * W + 2 * c];
        b = p[(2 * r) * W + 2 * c + 1];
        d = p[(2 * r + 1) * W + 2 * c];
        f = p[(2 * r + 1) * W + 2 * c + 1];
        if (mode) begin
            s = a + b + d + f;
            res = (s >= 0) ? s / 4 : -((-s + 3) / 4);
        end else begin
            res = a;
            if (b > res) res = b;
            if (d > res) res = d;
            if (f > res) res = f;
        end
        if (relu && res < 0) res = 0;
        return res;
    endfunction

    // Drive nbeats pixels of a frame. gaps inserts random idle cycles (always
    // before the last pixel); noise flips the mode inputs from beat 3 onward.
    task automatic send_frame(input frame_t p, input bit mode, input bit relu,
                              input bit gaps, input bit noise, input int nbeats);
        exp_t x;
        int   r, c, ng;
        for (int i = 0; i < nbeats; i++) begin
            if (gaps && i > 0 && (i == NP - 1 || $urandom_range(1, 0) == 1)) begin
                ng = $urandom_range(3, 1);
                for (int g = 0; g < ng; g++) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    in_data  = DW'($urandom);
                end
            end
            @(negedge clk);
            in_valid  = 1'b1;
            in_data   = DW'(p[i]);
            pool_mode = (noise && i >= 3) ? ~mode : mode;
            relu_en   = (noise && i >= 3) ? ~relu : relu;
            r = i / W;
            c = i % W;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                x.val = pool_ref(p, r / 2, c / 2, mode, relu);
                x.fd  = (i == NP - 1) ? 1 : 0;
                x.due = cyc + 1;
                sb_q.push_back(x);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Output monitor: sampled 1 time unit after each active edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (!in_reset) begin
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check("spurious_valid", sb_q.size(), 1);
                end else begin
                    e = sb_q.pop_front();
                    check("out_data", int'(out_data), e.val);
                    check("frame_done", int'(frame_done), e.fd);
                    check("latency_cycle", cyc, e.due);
                end
            end else begin
                check("idle_data", int'(out_data), 0);
                check("idle_frame_done", int'(frame_done), 0);
                if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
                    check("missing_valid", int'(out_valid), 1);
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    frame_t ramp, neg_win, all_min, all_max;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        in_reset  = 1'b1;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        pool_mode = 1'b0;
        relu_en   = 1'b0;

        for (int i = 0; i < NP; i++) begin
            ramp[i]    = i;
            neg_win[i] = 0;
            all_min[i] = -32768;
            all_max[i] = 32767;
        end
        neg_win[0] = -1;
        neg_win[1] = -2;
        neg_win[4] = -3;
        neg_win[5] = -4;

        #12;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_data", int'(out_data), 0);
        check("reset_frame_done", int'(frame_done), 0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_reset = 1'b0;
        idle(2);

        // Ramp, max then average.
        send_frame(ramp, 1'b0, 1'b0, 1'b0, 1'b0, NP);
        idle(2);
        send_frame(ramp, 1'b1, 1'b0, 1'b0, 1'b0, NP);
        idle(2);

        // Negative window, average, without and with ReLU.
        send_frame(neg_win, 1'b1, 1'b0, 1'b0, 1'b0, NP);
        idle(1);
        send_frame(neg_win, 1'b1, 1'b1, 1'b0, 1'b1, NP);
        idle(2);

        // Extremes: max of most-negative, average of most-positive.
        send_frame(all_min, 1'b0, 1'b0, 1'b0, 1'b0, NP);
        idle(1);
        send_frame(all_max, 1'b1, 1'b0, 1'b0, 1'b0, NP);
        idle(1);
        send_frame(all_max, 1'b1, 1'b0, 1'b1, 1'b0, NP);
        idle(2);

        // Back to back: mode toggled mid-frame and at the next frame start.
        send_frame(ramp, 1'b0, 1'b0, 1'b0, 1'b1, NP);
        send_frame(ramp, 1'b1, 1'b0, 1'b0, 1'b0, NP);
        idle(3);

        // Reset mid-frame after 9 beats, while window 1 output is showing.
        send_frame(ramp, 1'b0, 1'b0, 1'b0, 1'b0, 9);
        #2;
        in_reset = 1'b1;
        rst_n    = 1'b0;
        #1;
        check("async_rst_valid", int'(out_valid), 0);
        check("async_rst_data", int'(out_data), 0);
        check("async_rst_fd", int'(frame_done), 0);
        check("rst_pending", sb_q.size(), 0);
        sb_q.delete();
        in_valid = 1'b0;
        idle(2);
        rst_n    = 1'b1;
        in_reset = 1'b0;
        idle(1);
        send_frame(ramp, 1'b0, 1'b0, 1'b0, 1'b0, NP);
        idle(5);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_pool2x2.md
Name: conv_pool2x2

Overview:
- Downstream stage of the separable-convolution engine.
- Consumes the serial stream of signed convolution results: one H x W frame, raster order, one value per valid beat.
- Applies 2x2 stride-2 pooling (max or average), then optional ReLU, and emits (H/2)*(W/2) pooled values serially.
- Streams on the fly, with a half-row partial buffer; no full-frame storage.

Parameters:
- DW, 16, data width of input and output samples (signed two's complement).
- W, 4, frame width in samples; even, >= 2.
- H, 4, frame height in rows; even, >= 2.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  in_data carries a valid sample this cycle.
- in_data  input  DW  signed convolution result, raster order.
- pool_mode  input  1  0 = max pooling, 1 = average pooling; sampled on first beat of a frame.
- relu_en  input  1  1 = clamp negative pooled results to 0; sampled on first beat of a frame.
- out_valid  output  1  out_data valid this cycle.
- out_data  output  DW  signed pooled result.
- frame_done  output  1  one-cycle pulse coincident with the last pooled output of a frame.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, frame_done=0, FSM=IDLE, row/col counters=0, partial buffer=0, latched mode/relu=0.

FSM:
- IDLE: no frame in progress.
  - in_valid=1 -> latch pool_mode and relu_en, accept the beat as pixel (0,0), go to ACC.
- ACC: each in_valid=1 beat is accepted and advances col (0..W-1, wrap to 0 with row+1).
  - in_valid=0 is a gap: no state change, nothing accepted, no timeout.
  - On accepting pixel (H-1, W-1), return to IDLE; counters clear.
- A beat arriving the cycle after the last pixel is pixel (0,0) of a new frame; no idle cycle is required between frames.

Pooling datapath:
- Window k covers rows 2r..2r+1 and columns 2c..2c+1; k = r*(W/2)+c.
- Partial buffer: W/2 entries, each DW+2 bits, indexed by col/2.
- Even row, even col: entry = x.
- Even row, odd col:
  - max mode: entry = max(entry, x).
  - avg mode: entry = entry + x.
- Odd row, even col: fold x into the entry the same way.
- Odd row, odd col: final = fold(entry, x).
- All max comparisons are signed. Avg sums are sign-extended to DW+2 bits, so no overflow is possible.
- Average = sum >>> 2 (arithmetic shift, floor toward -inf); result fits in DW.
- ReLU (latched relu_en=1): result < 0 -> 0.
- pool_mode and relu_en changes mid-frame are ignored; the latched values apply until frame end.

Output timing:
- Output is registered. out_valid=1 exactly one cycle after the beat that accepts the bottom-right pixel of a window; out_data holds that window's result.
- out_valid=0 otherwise; out_data holds 0 when out_valid=0.
- Emission order is raster over windows; one output per window.
- frame_done=1 in the same cycle as the output for window (H/2)*(W/2)-1.

Boundary conditions:
- Reset mid-frame: partial frame is discarded; the next accepted beat is pixel (0,0).
- in_valid held continuously for multiple frames: frames are processed back to back.
- A gap immediately before the last pixel delays the output; nothing else changes.
- Extreme values: max of four -2^(DW-1) = -2^(DW-1). Avg of four 2^(DW-1)-1 = 2^(DW-1)-1, with no wrap.

Test Plan:
- Max mode, relu off, W=H=4, input 0..15 on consecutive beats -> outputs 5, 7, 13, 15; out_valid 1 cycle after beats 5, 7, 13, 15; frame_done with the value 15.
- Avg mode, same stimulus -> outputs 2, 4, 10, 12 (sums 10, 18, 42, 50 floored).
- Avg mode, relu off, window {-1,-2,-3,-4}, other pixels 0 -> window output -3; same frame with relu on -> 0. Max mode, all 16 = -32768 -> four outputs of -32768.
- Avg mode, all pixels 32767 -> four outputs of 32767. Same stimulus with random in_valid gaps of 1-3 cycles -> identical values, each 1 cycle after its completing beat.
- Two frames back to back with no idle cycle, pool_mode toggled on beat 3 of frame 1 and at the start of frame 2 -> frame 1 fully uses its initial mode, frame 2 uses the new mode; frame_done pulses twice.
- Assert rst_n=0 after 9 beats -> outputs clear asynchronously. Then a fresh 0..15 frame in max mode -> 5, 7, 13, 15, with no leftover partial data.
